pc_fetch_unit: RTL and testbench

//   Front-end of the 16-bit pipeline: owns the PC register, issues instruction-memory

---
 rtl/pc_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front-end: owns the PC, runs the imem req/ack handshake,
// and feeds {inst, PC, valid} to IF/ID with a one-entry skid buffer for stalls.
module pc_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INST_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pcNewFlag_i,
   input  logic [ADDR_W-1:0] pcNew_i,
   input  logic              stall_i,
   input  logic              imemAck_i,
   input  logic [INST_W-1:0] imemData_i,
   output logic              imemReq_o,
   output logic [ADDR_W-1:0] imemAddr_o,
   output logic [INST_W-1:0] inst_o,
   output logic [ADDR_W-1:0] instPC_o,
   output logic              instValid_o,
   output logic              flush_o
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_inc_s;
   logic              req_r;
   logic [ADDR_W-1:0] addr_r;
   logic [INST_W-1:0] inst_r;
   logic [ADDR_W-1:0] inst_pc_r;
   logic              valid_r;
   logic              flush_r;
   logic [INST_W-1:0] skid_inst_r;
   logic [ADDR_W-1:0] skid_pc_r;
   logic              skid_valid_r;

   assign pc_inc_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Fetch FSM; request/address and IF/ID outputs are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_BOOT;
         pc_r         <= RESET_PC;
         req_r        <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         inst_r       <= {INST_W{1'b0}};
         inst_pc_r    <= {ADDR_W{1'b0}};
         valid_r      <= 1'b0;
         flush_r      <= 1'b0;
         skid_inst_r  <= {INST_W{1'b0}};
         skid_pc_r    <= {ADDR_W{1'b0}};
         skid_valid_r <= 1'b0;
      end else begin
         flush_r <= pcNewFlag_i;
         if (pcNewFlag_i) begin
            // Redirect wins everywhere; an open handshake keeps its address until acked.
            pc_r         <= pcNew_i;
            valid_r      <= 1'b0;
            skid_valid_r <= 1'b0;
            case (state_r)
               ST_FETCH: begin
                  req_r <= 1'b1;
                  if (imemAck_i) begin
                     state_r <= ST_FETCH;
                     addr_r  <= pcNew_i;
                  end else begin
                     state_r <= ST_DRAIN;
                  end
               end
               ST_DRAIN: begin
                  state_r <= ST_DRAIN;
                  req_r   <= 1'b1;
               end
               default: begin
                  state_r <= ST_FETCH;
                  req_r   <= 1'b1;
                  addr_r  <= pcNew_i;
               end
            endcase
         end else begin
            case (state_r)
               ST_BOOT: begin
                  state_r <= ST_FETCH;
                  req_r   <= 1'b1;
                  addr_r  <= pc_r;
               end
               ST_FETCH: begin
                  if (imemAck_i) begin
                     pc_r <= pc_inc_s;
                     if (stall_i) begin
                        skid_inst_r  <= imemData_i;
                        skid_pc_r    <= pc_r;
                        skid_valid_r <= 1'b1;
                        state_r      <= ST_HOLD;
                        req_r        <= 1'b0;
                     end else begin
                        inst_r    <= imemData_i;
                        inst_pc_r <= pc_r;
                        valid_r   <= 1'b1;
                        addr_r    <= pc_inc_s;
                     end
                  end else if (!stall_i) begin
                     valid_r <= 1'b0;
                  end
               end
               ST_HOLD: begin
                  if (!stall_i) begin
                     inst_r       <= skid_inst_r;
                     inst_pc_r    <= skid_pc_r;
                     valid_r      <= skid_valid_r;
                     skid_valid_r <= 1'b0;
                     state_r      <= ST_FETCH;
                     req_r        <= 1'b1;
                     addr_r       <= pc_r;
                  end
               end
               ST_DRAIN: begin
                  // Wrong-path data is dropped; the redirect target is issued next.
                  if (imemAck_i) begin
                     state_r <= ST_FETCH;
                     req_r   <= 1'b1;
                     addr_r  <= pc_r;
                  end
               end
               default: begin
                  state_r <= ST_BOOT;
                  req_r   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign imemReq_o   = req_r;
   assign imemAddr_o  = addr_r;
   assign inst_o      = inst_r;
   assign instPC_o    = inst_pc_r;
   assign instValid_o = valid_r;
   assign flush_o     = flush_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural instruction memory
// (data = ~address, configurable ack latency, optional forced ack).
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        pcNewFlag_i;
   logic [15:0] pcNew_i;
   logic        stall_i;
   logic        imemAck_i;
   logic [15:0] imemData_i;
   logic        imemReq_o;
   logic [15:0] imemAddr_o;
   logic [15:0] inst_o;
   logic [15:0] instPC_o;
   logic        instValid_o;
   logic        flush_o;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;
   int wait_cnt;
   logic ack_force;

   pc_fetch_unit #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .pcNewFlag_i(pcNewFlag_i), .pcNew_i(pcNew_i),
      .stall_i(stall_i), .imemAck_i(imemAck_i), .imemData_i(imemData_i),
      .imemReq_o(imemReq_o), .imemAddr_o(imemAddr_o), .inst_o(inst_o),
      .instPC_o(instPC_o), .instValid_o(instValid_o), .flush_o(flush_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ack arrives on the lat-th cycle of a held request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wait_cnt <= 0;
      else if (imemReq_o && !imemAck_i) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end
   assign imemAck_i  = ack_force | (imemReq_o && (wait_cnt >= lat - 1));
   assign imemData_i = ~imemAddr_o;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; pcNewFlag_i = 1'b0; pcNew_i = 16'h0000; stall_i = 1'b0;
      lat = 1; ack_force = 1'b0;
      tick(); tick();
      chk("rst_req",   {31'd0, imemReq_o},   32'd0);
      chk("rst_addr",  {16'd0, imemAddr_o},  32'd0);
      chk("rst_inst",  {16'd0, inst_o},      32'd0);
      chk("rst_pc",    {16'd0, instPC_o},    32'd0);
      chk("rst_valid", {31'd0, instValid_o}, 32'd0);
      chk("rst_flush", {31'd0, flush_o},     32'd0);

      // 1: boot and zero-wait streaming
      rst_n = 1'b1;
      tick();
      chk("boot_req",   {31'd0, imemReq_o},   32'd1);
      chk("boot_addr",  {16'd0, imemAddr_o},  32'h0000);
      chk("boot_valid", {31'd0, instValid_o}, 32'd0);
      tick();
      chk("s0_valid", {31'd0, instValid_o}, 32'd1);
      chk("s0_pc",    {16'd0, instPC_o},    32'h0000);
      chk("s0_inst",  {16'd0, inst_o},      32'hFFFF);
      chk("s0_addr",  {16'd0, imemAddr_o},  32'h0001);
      tick();
      chk("s1_pc",   {16'd0, instPC_o},   32'h0001);
      chk("s1_inst", {16'd0, inst_o},     32'hFFFE);
      chk("s1_addr", {16'd0, imemAddr_o}, 32'h0002);
      tick();
      chk("s2_pc", {16'd0, instPC_o}, 32'h0002);
      tick();
      chk("s3_pc", {16'd0, instPC_o}, 32'h0003);
      tick();
      chk("s4_pc",   {16'd0, instPC_o},   32'h0004);
      chk("s4_addr", {16'd0, imemAddr_o}, 32'h0005);

      // 2: stall while addr 5 is acked
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_req",   {31'd0, imemReq_o},   32'd0);
         chk("hold_pc",    {16'd0, instPC_o},    32'h0004);
         chk("hold_inst",  {16'd0, inst_o},      32'hFFFB);
         chk("hold_valid", {31'd0, instValid_o}, 32'd1);
      end
      stall_i = 1'b0;
      tick();
      chk("skid_pc",    {16'd0, instPC_o},    32'h0005);
      chk("skid_inst",  {16'd0, inst_o},      32'hFFFA);
      chk("skid_valid", {31'd0, instValid_o}, 32'd1);
      chk("resume_req", {31'd0, imemReq_o},   32'd1);
      chk("resume_addr",{16'd0, imemAddr_o},  32'h0006);
      tick();
      chk("s6_pc", {16'd0, instPC_o}, 32'h0006);
      tick();
      chk("s7_pc",   {16'd0, instPC_o},   32'h0007);
      chk("s7_addr", {16'd0, imemAddr_o}, 32'h0008);

      // 3: redirect to 0x40 with same-cycle ack of addr 8
      pcNewFlag_i = 1'b1; pcNew_i = 16'h0040;
      tick();
      pcNewFlag_i = 1'b0;
      chk("rd_flush", {31'd0, flush_o},     32'd1);
      chk("rd_valid", {31'd0, instValid_o}, 32'd0);
      chk("rd_addr",  {16'd0, imemAddr_o},  32'h0040);
      tick();
      chk("rd_flush_end", {31'd0, flush_o},     32'd0);
      chk("rd_tgt_valid", {31'd0, instValid_o}, 32'd1);
      chk("rd_tgt_pc",    {16'd0, instPC_o},    32'h0040);
      chk("rd_tgt_inst",  {16'd0, inst_o},      32'hFFBF);
      chk("rd_next_addr", {16'd0, imemAddr_o},  32'h0041);

      // 4: slow memory, redirect to 0x80 while 0x10 is outstanding
      pcNewFlag_i = 1'b1; pcNew_i = 16'h0010;
      tick();
      pcNewFlag_i = 1'b0; lat = 3;
      chk("sl_addr10", {16'd0, imemAddr_o}, 32'h0010);
      tick();
      chk("sl_req",   {31'd0, imemReq_o},  32'd1);
      chk("sl_addr1", {16'd0, imemAddr_o}, 32'h0010);
      pcNewFlag_i = 1'b1; pcNew_i = 16'h0080;
      tick();
      pcNewFlag_i = 1'b0;
      chk("dr_addr",  {16'd0, imemAddr_o}, 32'h0010);
      chk("dr_req",   {31'd0, imemReq_o},  32'd1);
      chk("dr_flush", {31'd0, flush_o},    32'd1);
      tick();
      chk("dr_new_addr", {16'd0, imemAddr_o},  32'h0080);
      chk("dr_discard",  {31'd0, instValid_o}, 32'd0);
      chk("dr_oldpc",    {16'd0, instPC_o},    32'h0040);
      tick(); tick();
      chk("sl_wait_valid", {31'd0, instValid_o}, 32'd0);
      tick();
      chk("sl80_pc",    {16'd0, instPC_o},    32'h0080);
      chk("sl80_inst",  {16'd0, inst_o},      32'hFF7F);
      chk("sl80_valid", {31'd0, instValid_o}, 32'd1);
      chk("sl81_addr",  {16'd0, imemAddr_o},  32'h0081);

      // 5: PC wrap
      lat = 1; pcNewFlag_i = 1'b1; pcNew_i = 16'hFFFF;
      tick();
      pcNewFlag_i = 1'b0;
      chk("wr_addr", {16'd0, imemAddr_o}, 32'hFFFF);
      tick();
      chk("wr_pc0",   {16'd0, instPC_o},   32'hFFFF);
      chk("wr_inst0", {16'd0, inst_o},     32'h0000);
      chk("wr_addr1", {16'd0, imemAddr_o}, 32'h0000);
      tick();
      chk("wr_pc1",   {16'd0, instPC_o},   32'h0000);
      chk("wr_inst1", {16'd0, inst_o},     32'hFFFF);

      // 6: reset during a pending, stalled request
      lat = 3; stall_i = 1'b1;
      tick();
      chk("pend_req",  {31'd0, imemReq_o},  32'd1);
      chk("pend_addr", {16'd0, imemAddr_o}, 32'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_req",   {31'd0, imemReq_o},   32'd0);
      chk("ar_addr",  {16'd0, imemAddr_o},  32'd0);
      chk("ar_inst",  {16'd0, inst_o},      32'd0);
      chk("ar_pc",    {16'd0, instPC_o},    32'd0);
      chk("ar_valid", {31'd0, instValid_o}, 32'd0);
      chk("ar_flush", {31'd0, flush_o},     32'd0);
      ack_force = 1'b1;
      tick(); tick();
      rst_n = 1'b1; stall_i = 1'b0; lat = 1;
      tick();
      chk("rb_stale_valid", {31'd0, instValid_o}, 32'd0);
      chk("rb_req",         {31'd0, imemReq_o},   32'd1);
      chk("rb_addr",        {16'd0, imemAddr_o},  32'h0000);
      ack_force = 1'b0;
      tick();
      chk("rb_valid", {31'd0, instValid_o}, 32'd1);
      chk("rb_pc",    {16'd0, instPC_o},    32'h0000);
      chk("rb_inst",  {16'd0, inst_o},      32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
